// File: rtl/axis_seq_gen_check.sv
// AXI-Stream incrementing-sequence generator plus a checker that verifies such a sequence.
// Generator paces beats with optional idle gaps; checker flags data/last errors and keeps statistics.
module axis_seq_gen_check #(
   parameter int          C_AXIS_TDATA_WIDTH = 32,
   parameter int          PACKET_WORDS       = 14,
   parameter int          GAP_CYCLES         = 2,
   parameter logic [63:0] START_VALUE        = 64'd1
) (
   input  logic                              axis_aclk,
   input  logic                              axis_aresetn,
   input  logic                              enable,
   output logic                              m_axis_tvalid,
   output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   input  logic                              s_axis_tvalid,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tstrb,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   input  logic                              accept_en,
   output logic                              err_data,
   output logic                              err_last,
   output logic [15:0]                       err_count,
   output logic [31:0]                       word_count,
   output logic [15:0]                       pkt_count
);
   localparam int W  = C_AXIS_TDATA_WIDTH;
   localparam int IW = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [W-1:0]  START_W  = START_VALUE[W-1:0];
   localparam logic [IW-1:0] IDX_LAST = IW'(PACKET_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [GW-1:0]   r_gap_cnt;
   logic [GW-1:0]   w_gap_next;
   logic [W-1:0]    r_gen_value;
   logic [IW-1:0]   r_word_idx;
   logic            w_hs;
   logic            w_idx_last;

   assign w_hs       = (r_state == ST_SEND) && m_axis_tready;
   assign w_idx_last = (r_word_idx == IDX_LAST);

   always_comb begin
      w_state_next = r_state;
      w_gap_next   = r_gap_cnt;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_state_next = ST_SEND;
         end
         ST_SEND: begin
            if (w_hs) begin
               if (GAP_CYCLES == 0) begin
                  w_state_next = (enable || !w_idx_last) ? ST_SEND : ST_IDLE;
               end else begin
                  w_state_next = ST_GAP;
                  w_gap_next   = GW'(GAP_CYCLES - 1);
               end
            end
         end
         ST_GAP: begin
            // Stopping is only allowed once the packet has closed (word_idx back at 0).
            if (r_gap_cnt == '0) begin
               w_state_next = (enable || (r_word_idx != '0)) ? ST_SEND : ST_IDLE;
            end else begin
               w_gap_next = r_gap_cnt - GW'(1);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         r_state     <= ST_IDLE;
         r_gap_cnt   <= '0;
         r_gen_value <= START_W;
         r_word_idx  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_gap_cnt <= w_gap_next;
         if (w_hs) begin
            r_gen_value <= r_gen_value + W'(1);
            r_word_idx  <= w_idx_last ? '0 : r_word_idx + IW'(1);
         end
      end
   end

   assign m_axis_tvalid = (r_state == ST_SEND);
   assign m_axis_tdata  = r_gen_value;
   assign m_axis_tstrb  = '1;
   assign m_axis_tlast  = m_axis_tvalid && w_idx_last;

   logic            r_s_tready;
   logic [W-1:0]    r_expected;
   logic [IW-1:0]   r_rx_idx;
   logic            r_err_data;
   logic            r_err_last;
   logic [15:0]     r_err_count;
   logic [31:0]     r_word_count;
   logic [15:0]     r_pkt_count;
   logic            w_accept;
   logic            w_rx_last;
   logic            w_data_bad;
   logic            w_last_bad;
   logic            w_unused_tstrb;

   assign w_accept       = s_axis_tvalid && r_s_tready;
   assign w_rx_last      = (r_rx_idx == IDX_LAST);
   assign w_data_bad     = (s_axis_tdata != r_expected);
   assign w_last_bad     = (s_axis_tlast != w_rx_last);
   assign w_unused_tstrb = &{1'b0, s_axis_tstrb};

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         r_s_tready   <= 1'b0;
         r_expected   <= START_W;
         r_rx_idx     <= '0;
         r_err_data   <= 1'b0;
         r_err_last   <= 1'b0;
         r_err_count  <= '0;
         r_word_count <= '0;
         r_pkt_count  <= '0;
      end else begin
         r_s_tready <= accept_en;
         r_err_data <= w_accept && w_data_bad;
         r_err_last <= w_accept && w_last_bad;
         if (w_accept) begin
            // Resynchronise on the received value so one bad word yields one error.
            r_expected   <= s_axis_tdata + W'(1);
            r_rx_idx     <= (s_axis_tlast || w_rx_last) ? '0 : r_rx_idx + IW'(1);
            r_word_count <= r_word_count + 32'd1;
            if (s_axis_tlast) r_pkt_count <= r_pkt_count + 16'd1;
            if ((w_data_bad || w_last_bad) && (r_err_count != 16'hFFFF)) begin
               r_err_count <= r_err_count + 16'd1;
            end
         end
      end
   end

   assign s_axis_tready = r_s_tready;
   assign err_data      = r_err_data;
   assign err_last      = r_err_last;
   assign err_count     = r_err_count;
   assign word_count    = r_word_count;
   assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_seq_gen_check.sv
// Bench for axis_seq_gen_check: two instances (gapped 32-bit, back-to-back 8-bit wrap) checked
// every cycle against a sequence-level model, plus literal checks of key scenarios.
module tb_axis_seq_gen_check;
   localparam int          AW = 32, APW = 14, AG = 2;
   localparam logic [63:0] AS = 64'd1;
   localparam int          BW = 8,  BPW = 4,  BG = 0;
   localparam logic [63:0] BS = 64'd250;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en_a, acc_a, rnd_a, loop_a, inj_v, inj_l;
   logic [31:0] inj_d;
   logic [3:0]  inj_strb;
   logic        en_b, acc_b, rnd_b;

   logic        a_m_tvalid, a_m_tlast, a_m_tready, a_s_tvalid, a_s_tlast, a_s_tready, a_err_d, a_err_l;
   logic [31:0] a_m_tdata, a_s_tdata, a_wc;
   logic [3:0]  a_m_tstrb, a_s_tstrb;
   logic [15:0] a_ec, a_pc;

   logic        b_m_tvalid, b_m_tlast, b_m_tready, b_s_tvalid, b_s_tlast, b_s_tready, b_err_d, b_err_l;
   logic [7:0]  b_m_tdata, b_s_tdata;
   logic [0:0]  b_m_tstrb, b_s_tstrb;
   logic [31:0] b_wc;
   logic [15:0] b_ec, b_pc;

   assign a_s_tvalid = loop_a ? (a_m_tvalid & rnd_a) : inj_v;
   assign a_s_tdata  = loop_a ? a_m_tdata : inj_d;
   assign a_s_tlast  = loop_a ? a_m_tlast : inj_l;
   assign a_s_tstrb  = inj_strb;
   assign a_m_tready = loop_a ? (a_s_tready & rnd_a) : rnd_a;

   assign b_s_tvalid = b_m_tvalid & rnd_b;
   assign b_s_tdata  = b_m_tdata;
   assign b_s_tlast  = b_m_tlast;
   assign b_s_tstrb  = inj_strb[0:0];
   assign b_m_tready = b_s_tready & rnd_b;

   axis_seq_gen_check #(.C_AXIS_TDATA_WIDTH(AW), .PACKET_WORDS(APW), .GAP_CYCLES(AG), .START_VALUE(AS)) u_a (
      .axis_aclk(clk), .axis_aresetn(rst_n), .enable(en_a),
      .m_axis_tvalid(a_m_tvalid), .m_axis_tdata(a_m_tdata), .m_axis_tstrb(a_m_tstrb),
      .m_axis_tlast(a_m_tlast), .m_axis_tready(a_m_tready),
      .s_axis_tvalid(a_s_tvalid), .s_axis_tdata(a_s_tdata), .s_axis_tstrb(a_s_tstrb),
      .s_axis_tlast(a_s_tlast), .s_axis_tready(a_s_tready), .accept_en(acc_a),
      .err_data(a_err_d), .err_last(a_err_l), .err_count(a_ec), .word_count(a_wc), .pkt_count(a_pc));

   axis_seq_gen_check #(.C_AXIS_TDATA_WIDTH(BW), .PACKET_WORDS(BPW), .GAP_CYCLES(BG), .START_VALUE(BS)) u_b (
      .axis_aclk(clk), .axis_aresetn(rst_n), .enable(en_b),
      .m_axis_tvalid(b_m_tvalid), .m_axis_tdata(b_m_tdata), .m_axis_tstrb(b_m_tstrb),
      .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready),
      .s_axis_tvalid(b_s_tvalid), .s_axis_tdata(b_s_tdata), .s_axis_tstrb(b_s_tstrb),
      .s_axis_tlast(b_s_tlast), .s_axis_tready(b_s_tready), .accept_en(acc_b),
      .err_data(b_err_d), .err_last(b_err_l), .err_count(b_ec), .word_count(b_wc), .pkt_count(b_pc));

   int errors = 0;
   int checks = 0;

   // Model state, index 0 = instance A, 1 = instance B.
   int          n_gen[2];
   bit          pv[2];
   int          gl[2];
   bit          ptr_m[2];
   logic [63:0] ex_m[2];
   int          rx_m[2];
   bit          ped_m[2], pel_m[2];
   logic [63:0] ec_m[2], wc_m[2], pc_m[2];
   int          hs_cnt[2] = '{0, 0};
   logic [63:0] logd[2][64];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step(input int id, input logic rst, input logic vld, input logic rdy,
                             input logic lst, input logic [63:0] dat, input logic strb_ok,
                             input logic en, input logic sv, input logic sr, input logic sl,
                             input logic [63:0] sd, input logic acc, input logic ed, input logic el,
                             input logic [63:0] ec, input logic [63:0] wc, input logic [63:0] pc);
      int          w, pw, g;
      logic [63:0] st, mask;
      string       p;
      bit          inc;
      w    = (id == 0) ? AW : BW;
      pw   = (id == 0) ? APW : BPW;
      g    = (id == 0) ? AG : BG;
      st   = (id == 0) ? AS : BS;
      p    = (id == 0) ? "A" : "B";
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      if (!rst) begin
         chk({p, ".rst_tvalid"}, {63'b0, vld}, 64'd0);
         chk({p, ".rst_tlast"},  {63'b0, lst}, 64'd0);
         chk({p, ".rst_tready"}, {63'b0, sr},  64'd0);
         chk({p, ".rst_err"},    {62'b0, ed, el}, 64'd0);
         chk({p, ".rst_counts"}, ec | wc | pc, 64'd0);
         n_gen[id] = 0; pv[id] = 1'b0; gl[id] = 0; ptr_m[id] = 1'b0;
         ex_m[id] = st & mask; rx_m[id] = 0; ped_m[id] = 1'b0; pel_m[id] = 1'b0;
         ec_m[id] = 0; wc_m[id] = 0; pc_m[id] = 0; hs_cnt[id] = 0;
         return;
      end
      chk({p, ".tvalid"},     {63'b0, vld},     {63'b0, pv[id]});
      chk({p, ".tstrb"},      {63'b0, strb_ok}, 64'd1);
      chk({p, ".tready"},     {63'b0, sr},      {63'b0, ptr_m[id]});
      chk({p, ".err_data"},   {63'b0, ed},      {63'b0, ped_m[id]});
      chk({p, ".err_last"},   {63'b0, el},      {63'b0, pel_m[id]});
      chk({p, ".err_count"},  ec, ec_m[id]);
      chk({p, ".word_count"}, wc, wc_m[id]);
      chk({p, ".pkt_count"},  pc, pc_m[id]);
      if (vld) begin
         chk({p, ".tdata"}, dat, (st + 64'(n_gen[id])) & mask);
         chk({p, ".tlast"}, {63'b0, lst}, {63'b0, ((n_gen[id] % pw) == pw - 1)});
      end
      // Generator: next-cycle tvalid from the beat/gap/enable rules.
      if (vld && rdy) begin
         if (hs_cnt[id] < 64) logd[id][hs_cnt[id]] = dat;
         hs_cnt[id]++;
         n_gen[id]++;
         inc = (n_gen[id] % pw) != 0;
         if (g == 0) pv[id] = en || inc;
         else begin
            pv[id] = 1'b0;
            gl[id] = g;
         end
      end else if (gl[id] > 0) begin
         gl[id]--;
         inc = (n_gen[id] % pw) != 0;
         pv[id] = (gl[id] == 0) ? (en || inc) : 1'b0;
      end else if (vld) begin
         pv[id] = 1'b1;
      end else begin
         pv[id] = en;
      end
      // Checker: expected value, beat index and statistics.
      ptr_m[id] = acc;
      if (sv && sr) begin
         ped_m[id] = ((sd & mask) != ex_m[id]);
         pel_m[id] = (sl != (rx_m[id] == pw - 1));
         ex_m[id]  = (sd + 64'd1) & mask;
         rx_m[id]  = (sl || (rx_m[id] == pw - 1)) ? 0 : rx_m[id] + 1;
         wc_m[id]  = (wc_m[id] + 64'd1) & 64'hFFFF_FFFF;
         if (sl) pc_m[id] = (pc_m[id] + 64'd1) & 64'hFFFF;
         if ((ped_m[id] || pel_m[id]) && (ec_m[id] < 64'hFFFF)) ec_m[id] = ec_m[id] + 64'd1;
      end else begin
         ped_m[id] = 1'b0;
         pel_m[id] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      model_step(0, rst_n, a_m_tvalid, a_m_tready, a_m_tlast, {32'b0, a_m_tdata}, a_m_tstrb == 4'hF,
                 en_a, a_s_tvalid, a_s_tready, a_s_tlast, {32'b0, a_s_tdata}, acc_a, a_err_d, a_err_l,
                 {48'b0, a_ec}, {32'b0, a_wc}, {48'b0, a_pc});
      model_step(1, rst_n, b_m_tvalid, b_m_tready, b_m_tlast, {56'b0, b_m_tdata}, b_m_tstrb == 1'b1,
                 en_b, b_s_tvalid, b_s_tready, b_s_tlast, {56'b0, b_s_tdata}, acc_b, b_err_d, b_err_l,
                 {48'b0, b_ec}, {32'b0, b_wc}, {48'b0, b_pc});
   end

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_hs(input int id, input int target, input int budget, input string name);
      int c = 0;
      while (hs_cnt[id] < target && c < budget) begin
         cyc(1);
         c++;
      end
      chk(name, {63'b0, hs_cnt[id] >= target}, 64'd1);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      chk("rst_now_tvalid", {63'b0, a_m_tvalid}, 64'd0);
      chk("rst_now_tlast",  {63'b0, a_m_tlast},  64'd0);
      chk("rst_now_tready", {63'b0, a_s_tready}, 64'd0);
      chk("rst_now_counts", {32'b0, a_wc} | {48'b0, a_pc} | {48'b0, a_ec}, 64'd0);
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic inj(input logic [31:0] value, input logic last);
      inj_d = value;
      inj_l = last;
      inj_v = 1'b1;
      cyc(1);
      inj_v = 1'b0;
      inj_l = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      en_a = 0; acc_a = 0; rnd_a = 0; loop_a = 1; inj_v = 0; inj_l = 0; inj_d = 0; inj_strb = 0;
      en_b = 0; acc_b = 0; rnd_b = 0;
      cyc(3);
      rst_n = 1'b1;

      // Free-running loopback: two full packets on A, byte wrap on B.
      en_a = 1; acc_a = 1; rnd_a = 1;
      en_b = 1; acc_b = 1; rnd_b = 1;
      wait_hs(0, 28, 400, "A.two_packets_timeout");
      en_a = 0;
      chk("A.pkt_count_2",  {48'b0, a_pc}, 64'd2);
      chk("A.word_count_28", {32'b0, a_wc}, 64'd28);
      chk("A.no_errors",    {48'b0, a_ec}, 64'd0);
      chk("A.beat1",  logd[0][0],  64'd1);
      chk("A.beat14", logd[0][13], 64'd14);
      chk("A.beat15", logd[0][14], 64'd15);
      chk("A.beat28", logd[0][27], 64'd28);
      chk("B.beat1",  logd[1][0], 64'd250);
      chk("B.beat6",  logd[1][5], 64'd255);
      chk("B.beat7",  logd[1][6], 64'd0);
      chk("B.beat10", logd[1][9], 64'd3);
      chk("B.no_err_at_wrap", {48'b0, b_ec}, 64'd0);

      // Ready toggling on the gapless instance, then fully random traffic on both.
      for (int i = 0; i < 200; i++) begin
         rnd_b = i[0];
         cyc(1);
      end
      for (int i = 0; i < 2500; i++) begin
         en_a  = ($urandom % 4) != 0;
         acc_a = ($urandom % 5) != 0;
         rnd_a = ($urandom % 3) != 0;
         en_b  = ($urandom % 4) != 0;
         acc_b = ($urandom % 5) != 0;
         rnd_b = ($urandom % 2) != 0;
         inj_strb = 4'($urandom);
         cyc(1);
      end
      chk("A.loop_no_errors", {48'b0, a_ec}, 64'd0);
      chk("B.loop_no_errors", {48'b0, b_ec}, 64'd0);

      // Enable dropped mid-packet completes the packet, then reset mid-packet.
      reset_pulse();
      loop_a = 1; rnd_a = 1; acc_a = 1; en_a = 1;
      wait_hs(0, 5, 100, "A.five_beats_timeout");
      en_a = 0;
      cyc(100);
      chk("A.stop_word_count", {32'b0, a_wc}, 64'd14);
      chk("A.stop_pkt_count",  {48'b0, a_pc}, 64'd1);
      chk("A.stop_idle",       {63'b0, a_m_tvalid}, 64'd0);
      en_a = 1;
      wait_hs(0, 17, 100, "A.restart_timeout");
      reset_pulse();
      wait_hs(0, 1, 50, "A.after_reset_timeout");
      chk("A.after_reset_data", logd[0][0], 64'd1);

      // Injected data error followed by a correct resynchronised value.
      reset_pulse();
      loop_a = 0; en_a = 0; acc_a = 1; rnd_a = 1;
      cyc(2);
      inj(1, 0); inj(2, 0); inj(3, 0);
      inj(5, 0);
      chk("A.err_data_pulse", {63'b0, a_err_d}, 64'd1);
      inj(6, 0);
      chk("A.err_data_cleared", {63'b0, a_err_d}, 64'd0);
      cyc(1);
      chk("A.err_count_1", {48'b0, a_ec}, 64'd1);
      chk("A.inj_words_5", {32'b0, a_wc}, 64'd5);

      // Early tlast on beat 3, then a full clean packet.
      reset_pulse();
      cyc(2);
      inj(1, 0); inj(2, 0); inj(3, 1);
      chk("A.err_last_pulse", {63'b0, a_err_l}, 64'd1);
      chk("A.early_pkt",      {48'b0, a_pc}, 64'd1);
      for (int v = 4; v <= 17; v++) inj(32'(v), v == 17);
      cyc(1);
      chk("A.early_err_count", {48'b0, a_ec}, 64'd1);
      chk("A.early_pkt_2",     {48'b0, a_pc}, 64'd2);

      // Random injection with corrupted data and stray tlast.
      for (int i = 0; i < 300; i++) begin
         inj_v    = ($urandom % 2) != 0;
         inj_d    = 32'($urandom_range(0, 20));
         inj_l    = ($urandom % 6) == 0;
         acc_a    = ($urandom % 4) != 0;
         inj_strb = 4'($urandom);
         cyc(1);
      end
      inj_v = 0;
      cyc(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axis_seq_gen_check.md
AXIS_SEQ_GEN_CHECK -- requirements
Module: axis_seq_gen_check

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 32, data width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter PACKET_WORDS, default 14, beats per packet; SHALL be >= 1.
REQ-003 Parameter GAP_CYCLES, default 2, idle cycles inserted by the generator after each accepted beat; 0 is legal.
REQ-004 Parameter START_VALUE, default 1, first generated and first expected data value.
REQ-005 axis_aclk  in  1  single clock for all logic.
REQ-006 axis_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-007 enable  in  1  generator run request.
REQ-008 m_axis_tvalid out 1; m_axis_tdata out W; m_axis_tstrb out W/8; m_axis_tlast out 1; m_axis_tready in 1: generator stream.
REQ-009 s_axis_tvalid in 1; s_axis_tdata in W; s_axis_tstrb in W/8; s_axis_tlast in 1; s_axis_tready out 1: checker stream.
REQ-010 accept_en  in  1  checker back-pressure control; s_axis_tready SHALL equal accept_en, registered one cycle.
REQ-011 err_data out 1, err_last out 1: single-cycle error pulses.
REQ-012 err_count out 16, word_count out 32, pkt_count out 16: checker statistics.

Function
REQ-013 Beat transfer SHALL occur only on a cycle where tvalid and tready are both 1.
REQ-014 Generator FSM states: IDLE, SEND, GAP.
REQ-015 IDLE: when enable=1, enter SEND with m_axis_tvalid=1 on the next cycle.
REQ-016 SEND: tvalid, tdata and tlast SHALL hold stable until the handshake; tvalid SHALL NOT drop without a handshake.
REQ-017 On each handshake, gen_value increments by 1 mod 2^W, with all-ones wrapping to 0, and word_idx increments.
REQ-018 m_axis_tlast SHALL be 1 exactly on beat word_idx = PACKET_WORDS-1; word_idx then returns to 0.
REQ-019 After a handshake with GAP_CYCLES=0: stay in SEND, giving back-to-back beats, if enable=1 or the packet is incomplete; otherwise go to IDLE.
REQ-020 After a handshake with GAP_CYCLES>0: enter GAP with tvalid=0 for exactly GAP_CYCLES cycles.
REQ-021 At the end of GAP: go to SEND if enable=1 or word_idx != 0; otherwise go to IDLE.
REQ-022 Deasserting enable mid-packet SHALL NOT truncate the packet; the generator stops only at a packet boundary.
REQ-023 m_axis_tstrb SHALL be all ones.
REQ-024 Checker expected value: START_VALUE after reset; after each accepted beat, received value + 1 mod 2^W. A mismatch resynchronises to the received value.
REQ-025 err_data SHALL pulse 1 cycle after an accepted beat whose tdata != expected.
REQ-026 Checker rx_idx counts accepted beats; rx_idx returns to 0 after an accepted beat with tlast=1 or with rx_idx = PACKET_WORDS-1.
REQ-027 err_last SHALL pulse 1 cycle after an accepted beat where s_axis_tlast != (rx_idx == PACKET_WORDS-1).
REQ-028 err_count SHALL increase by 1 per accepted beat with any error, data and/or last, and saturate at 0xFFFF.
REQ-029 word_count SHALL increase on every accepted beat; pkt_count SHALL increase on every accepted beat with tlast=1; both wrap.
REQ-030 s_axis_tstrb SHALL be ignored.

Reset
REQ-031 axis_aresetn=0 SHALL immediately force m_axis_tvalid=0, m_axis_tlast=0 and s_axis_tready=0.
REQ-032 Reset SHALL clear err_data, err_last, err_count, word_count, pkt_count, word_idx and rx_idx to 0.
REQ-033 Reset SHALL return gen_value and the expected value to START_VALUE and the FSM to IDLE.
REQ-034 Reset during a packet SHALL abandon that packet; the next packet starts at START_VALUE, word_idx 0.
REQ-035 Release of reset SHALL take effect on the first axis_aclk rising edge after release.

Verification
REQ-036 Loopback m->s, enable=1, accept_en=1, m_tready=1, defaults -> 2 packets of values 1..14 and 15..28, tlast on 14 and 28; pkt_count=2, err_count=0.
REQ-037 GAP_CYCLES=0, tready toggling 1/0 -> tdata held stable while stalled, beats back-to-back when ready, no errors.
REQ-038 W=8, START_VALUE=250, loopback for 10 beats -> data 250..255, 0..3; no err_data at the wrap.
REQ-039 Inject s_tdata 5 where 4 is expected, then 6 -> one err_data pulse, err_count=1, no error on 6.
REQ-040 Inject tlast on beat 3 of 14 -> err_last pulse, pkt_count +1, rx_idx restarts at 0.
REQ-041 Drop enable after beat 5, then assert reset mid-packet on a second run -> first packet completes to beat 14 then IDLE; after reset tvalid=0 at once, counters 0, next data 1.
